// File: rtl/bb_uart_tx_if.sv
// bb_uart_tx_if: byte handshake into the UART transmitter.
// tx_data/tx_valid from producer, tx_ready back from the transmitter.
interface bb_uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/bb_uart_tx.sv
// bb_uart_tx: UART transmitter, one bit per rising edge of bd_clk.
// Ports: clk, nrst (async low), bd_clk (baud strobe source),
//        tx (slave handshake: tx_data/tx_valid/tx_ready),
//        txd (serial line, idle high), busy (frame or byte pending).
module bb_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        bd_clk,
    bb_uart_tx_if.slave tx,
    output logic        txd,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    state_t               state_d;
    logic                 bd_q;
    logic                 tick;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_d;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_d;
    logic                 stop_cnt;
    logic                 stop_cnt_d;
    logic                 par_q;
    logic                 par_d;
    logic                 txd_q;
    logic                 txd_d;
    logic                 load;
    logic                 accept;
    logic                 last_bit;
    logic                 stop_last;

    // bd_clk is generated on clk, so a plain edge detect is enough.
    assign tick      = bd_clk & ~bd_q;
    assign accept    = tx.tx_valid & ~hold_full;
    assign last_bit  = (bit_cnt == 3'(DATA_BITS - 1));
    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

    assign tx.tx_ready = ~hold_full;
    assign txd         = txd_q;
    assign busy        = (state != IDLE) | hold_full;

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            bd_q      <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state    <= state_d;
            bd_q     <= bd_clk;
            shift    <= shift_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            if (accept) begin
                hold      <= tx.tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Next-state logic; nothing moves without a tick.
    always_comb begin
        state_d = state;
        if (tick) begin
            unique case (state)
                IDLE:  if (hold_full) state_d = START;
                START: state_d = DATA;
                DATA: begin
                    if (last_bit)
                        state_d = (PARITY != 0) ? PAR : STOP;
                end
                PAR:   state_d = STOP;
                STOP: begin
                    if (stop_last)
                        state_d = hold_full ? START : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Line level and shift/counter updates for each tick.
    always_comb begin
        txd_d      = txd_q;
        shift_d    = shift;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        par_d      = par_q;
        load       = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        load  = 1'b1;
                        txd_d = 1'b0;
                    end
                end
                START: begin
                    txd_d     = shift[0];
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = shift >> 1;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (!last_bit) begin
                        txd_d = shift[1];
                    end else if (PARITY != 0) begin
                        txd_d = par_q;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
                PAR: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (!stop_last) begin
                        stop_cnt_d = stop_cnt + 1'b1;
                    end else if (hold_full) begin
                        // Back-to-back: next start bit, no idle gap.
                        load  = 1'b1;
                        txd_d = 1'b0;
                    end
                end
                default: txd_d = 1'b1;
            endcase
        end
        if (load) begin
            shift_d = hold;
            par_d   = (^hold) ^ (PARITY == 2);
        end
    end

endmodule

// File: tb/tb_bb_uart_tx.sv
// tb_bb_uart_tx: directed and random frames on three UART configs.
// Expected frames come from a bit-list model of the line format.
module tb_bb_uart_tx;

    localparam int P = 8;

    typedef bit bitq_t[$];

    logic       clk;
    logic       nrst;
    logic       bd_clk;
    logic [7:0] td [3];
    logic [2:0] tv;
    logic [2:0] rdy;
    logic [2:0] txdv;
    logic [2:0] bsy;

    int  tests = 0;
    int  fails = 0;
    int  bd_cnt;
    bit  bd_run;
    bit  bd_rose;

    bb_uart_tx_if #(.DATA_BITS(8)) if0 ();
    bb_uart_tx_if #(.DATA_BITS(8)) if1 ();
    bb_uart_tx_if #(.DATA_BITS(8)) if2 ();

    assign if0.tx_data  = td[0];
    assign if0.tx_valid = tv[0];
    assign rdy[0]       = if0.tx_ready;
    assign if1.tx_data  = td[1];
    assign if1.tx_valid = tv[1];
    assign rdy[1]       = if1.tx_ready;
    assign if2.tx_data  = td[2];
    assign if2.tx_valid = tv[2];
    assign rdy[2]       = if2.tx_ready;

    bb_uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) u_8n1 (
        .clk(clk), .nrst(nrst), .bd_clk(bd_clk), .tx(if0),
        .txd(txdv[0]), .busy(bsy[0])
    );

    bb_uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(2)) u_8o2 (
        .clk(clk), .nrst(nrst), .bd_clk(bd_clk), .tx(if1),
        .txd(txdv[1]), .busy(bsy[1])
    );

    bb_uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) u_8e1 (
        .clk(clk), .nrst(nrst), .bd_clk(bd_clk), .tx(if2),
        .txd(txdv[2]), .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud square wave, P clocks per bit, changing on falling clk.
    always @(negedge clk) begin
        bd_rose = 1'b0;
        if (bd_run) begin
            bd_cnt = (bd_cnt == P - 1) ? 0 : bd_cnt + 1;
            bd_clk = (bd_cnt < P / 2);
            if (bd_cnt == 0) bd_rose = 1'b1;
        end
    end

    function automatic int par_of(int idx);
        case (idx)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stops_of(int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    // Line-level picture of one frame.
    function automatic bitq_t frame_bits(logic [7:0] b, int idx);
        bitq_t q;
        int    par;
        par = par_of(idx);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        if (par != 0)
            q.push_back((($countones(b) % 2) == 1) ^ (par == 2));
        for (int s = 0; s < stops_of(idx); s++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 4 * P; n++) begin
            step();
            if (bd_rose) begin
                seen = 1'b1;
                break;
            end
        end
        chk("tick_wait", 32'(seen), 32'd1);
    endtask

    task automatic push(int idx, logic [7:0] b, bit keep);
        bit done;
        done    = 1'b0;
        td[idx] = b;
        tv[idx] = 1'b1;
        for (int n = 0; n < 40 * P; n++) begin
            if (rdy[idx]) begin
                done = 1'b1;
                step();
                break;
            end
            step();
        end
        if (!keep) tv[idx] = 1'b0;
        chk($sformatf("accept%0d", idx), 32'(done), 32'd1);
        chk($sformatf("rdy_drop%0d", idx), 32'(rdy[idx]), 32'd0);
        chk($sformatf("busy_acc%0d", idx), 32'(bsy[idx]), 32'd1);
    endtask

    task automatic check_frame(int idx, bitq_t bits, bit idle_after,
                               bit chk_rdy);
        wait_tick();
        foreach (bits[k]) begin
            for (int c = 0; c < P; c++) begin
                chk($sformatf("txd%0d b%0d c%0d", idx, k, c),
                    32'(txdv[idx]), 32'(bits[k]));
                if (c == 0)
                    chk($sformatf("busy%0d b%0d", idx, k),
                        32'(bsy[idx]), 32'd1);
                if (chk_rdy && k == 0 && c == 1)
                    chk($sformatf("rdy_back%0d", idx),
                        32'(rdy[idx]), 32'd1);
                step();
            end
        end
        if (idle_after) begin
            chk($sformatf("idle_txd%0d", idx), 32'(txdv[idx]), 32'd1);
            chk($sformatf("idle_busy%0d", idx), 32'(bsy[idx]), 32'd0);
        end
    endtask

    initial begin
        bitq_t      q;
        bitq_t      q2;
        logic [7:0] b;
        int         idx;

        nrst   = 1'b0;
        bd_clk = 1'b1;
        bd_cnt = 1;
        bd_run = 1'b0;
        tv     = '0;
        for (int i = 0; i < 3; i++) td[i] = '0;

        // Reset with bd_clk high, then quiet line after release.
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_txd", 32'(txdv[i]), 32'd1);
            chk("rst_rdy", 32'(rdy[i]), 32'd1);
            chk("rst_busy", 32'(bsy[i]), 32'd0);
        end
        nrst   = 1'b1;
        bd_run = 1'b1;
        for (int n = 0; n < 3 * P; n++) begin
            step();
            chk("post_rst_txd", 32'(txdv[0]), 32'd1);
            chk("post_rst_busy", 32'(bsy[0]), 32'd0);
        end

        // 8N1 single byte.
        push(0, 8'h55, 1'b0);
        check_frame(0, frame_bits(8'h55, 0), 1'b1, 1'b1);

        // Back-to-back with tx_valid held high.
        push(0, 8'hA5, 1'b1);
        fork
            push(0, 8'h3C, 1'b0);
        join_none
        q  = frame_bits(8'hA5, 0);
        q2 = frame_bits(8'h3C, 0);
        q  = {q, q2};
        check_frame(0, q, 1'b1, 1'b0);

        // Odd parity, two stops; then even parity.
        push(1, 8'h07, 1'b0);
        check_frame(1, frame_bits(8'h07, 1), 1'b1, 1'b1);
        push(2, 8'h07, 1'b0);
        check_frame(2, frame_bits(8'h07, 2), 1'b1, 1'b1);

        // Accept in the same cycle as a tick.
        for (int n = 0; n < 2 * P; n++) begin
            if (bd_cnt == P - 1) break;
            step();
        end
        b     = 8'($urandom);
        td[2] = b;
        tv[2] = 1'b1;
        step();
        tv[2] = 1'b0;
        chk("coin_acc", 32'(rdy[2]), 32'd0);
        chk("coin_nostart", 32'(txdv[2]), 32'd1);
        check_frame(2, frame_bits(b, 2), 1'b1, 1'b1);

        // Baud stall during the start bit.
        b = 8'($urandom);
        push(0, b, 1'b0);
        wait_tick();
        chk("stall_start", 32'(txdv[0]), 32'd0);
        bd_run = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("stall_hold", 32'(txdv[0]), 32'd0);
        end
        bd_run = 1'b1;
        q = frame_bits(b, 0);
        void'(q.pop_front());
        check_frame(0, q, 1'b1, 1'b0);

        // Reset during data bit 3 of 0xF0 with 0x12 held.
        push(0, 8'hF0, 1'b0);
        wait_tick();
        chk("f0_start", 32'(txdv[0]), 32'd0);
        push(0, 8'h12, 1'b0);
        for (int t = 0; t < 4; t++) wait_tick();
        step();
        step();
        chk("f0_bit3", 32'(txdv[0]), 32'd0);
        chk("f0_rdy_held", 32'(rdy[0]), 32'd0);
        nrst = 1'b0;
        #1;
        chk("abort_txd", 32'(txdv[0]), 32'd1);
        chk("abort_rdy", 32'(rdy[0]), 32'd1);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        repeat (3) step();
        nrst = 1'b1;
        for (int n = 0; n < 3 * P; n++) begin
            step();
            chk("no_0x12", 32'(txdv[0]), 32'd1);
        end
        push(0, 8'h81, 1'b0);
        check_frame(0, frame_bits(8'h81, 0), 1'b1, 1'b1);

        // Random bytes on random configurations.
        for (int r = 0; r < 6; r++) begin
            idx = int'($urandom_range(0, 2));
            b   = 8'($urandom);
            repeat ($urandom_range(0, P)) step();
            push(idx, b, 1'b0);
            check_frame(idx, frame_bits(b, idx), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bb_uart_tx.md
Name: bb_uart_tx

Overview:
- UART transmitter for the ispMACH 4256ZE breakout design; sits directly downstream of the baud clock generator.
- Runs on the 5 MHz oscillator clock and uses each rising edge of the baud square wave `bd_clk` as its bit-time strobe.
- Accepts bytes over a valid/ready handshake into a one-byte holding register, then serialises them LSB-first on `txd` as start / data / optional parity / stop frames.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal 5..8)
STOP_BITS, 1, number of stop bits (legal 1 or 2)
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  5 MHz system clock (osc_clk)
nrst  input  1  asynchronous active-low reset
bd_clk  input  1  baud square wave, synchronous to clk; one period = one bit time
tx_data  input  DATA_BITS  byte to send, sampled on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; transfer occurs when tx_valid & tx_ready at a clk rising edge
txd  output  1  serial line, idle high
busy  output  1  frame in progress, or holding register full

Behaviour:
- Reset is asynchronous and active-low (nrst low). Outputs immediately: txd=1, tx_ready=1, busy=0. FSM goes to IDLE, holding register is emptied, bit counter=0.
- Edge detect: bd_q <= bd_clk; tick = bd_clk & ~bd_q, one clk cycle wide.
  - bd_q resets to 1, so a high bd_clk at reset release creates no spurious tick.
  - No synchroniser is used, because bd_clk is generated on clk.
- Handshake:
  - On accept, the holding register loads tx_data and tx_ready drops on the next cycle.
  - tx_ready rises the cycle after the holding register moves into the shift register.
  - tx_data is ignored while tx_ready=0.
- FSM states: IDLE, START, DATA, PAR, STOP. All state changes occur only on tick cycles.
  - IDLE: txd=1. On tick with holding full, load shift register, empty holding, txd=0, go to START.
  - START: on tick, txd=shift[0], bit_cnt=0, go to DATA.
  - DATA: on tick, shift right and increment bit_cnt.
    - While bit_cnt < DATA_BITS-1, txd=next bit.
    - At the last bit: if PARITY!=0, txd=parity and go to PAR; else txd=1, stop_cnt=0, go to STOP.
  - PAR: on tick, txd=1 and go to STOP.
  - STOP: on tick, if stop_cnt < STOP_BITS-1, increment stop_cnt. Otherwise:
    - if holding is full, txd=0, load the shift register and go to START (back-to-back, no idle bit);
    - else go to IDLE.
- Parity bit: even = XOR of data bits; odd = inverse of that XOR. Computed from the loaded byte.
- Latency: the start bit begins at the first tick strictly after the accept cycle. A tick in the same cycle as the accept does not start the frame.
- Every bit is held exactly one bd_clk period, from tick edge to tick edge.
- busy = (state != IDLE) | holding full.
- bd_clk stalled: the FSM freezes and txd holds its current value.
- Reset mid-frame: txd returns high asynchronously. The frame is aborted and not resumed, and the held byte is discarded.

Test Plan:
- Reset check: hold nrst low with bd_clk=1, then release. Required: txd=1, tx_ready=1, busy=0, and no tick or line activity for 3 bd_clk periods.
- 8N1 single byte: send 0x55. Required txd sequence 0,1,0,1,0,1,0,1,0,1, each bit exactly one bd_clk period. The start bit falls one clk after a bd_clk rising edge. tx_ready low for one bd_clk period at most, busy high until the stop bit ends.
- Back-to-back 0xA5 then 0x3C, tx_valid held high:
  - the second byte is accepted while the first is serialising;
  - the first frame's stop bit is followed immediately by the second start bit;
  - there are 20 bit times total with no idle bit between frames.
- PARITY=2, STOP_BITS=2, send 0x07. Required: start 0, data 1,1,1,0,0,0,0,0, parity 0, then two high stop bits. With PARITY=1 the parity bit is 1.
- Reset mid-frame: pull nrst low during data bit 3 of 0xF0 while 0x12 is held. Required:
  - txd=1 the same cycle and tx_ready=1;
  - after release, the next send of 0x81 produces a clean frame;
  - 0x12 is never transmitted.
- Accept/tick coincidence: assert tx_valid in the same cycle as a tick in IDLE. Required: the start bit begins at the following tick, not the coincident one.
